sevseg_mux: RTL and testbench

SEVSEG_MUX -- requirements
Module: sevseg_mux

---
 rtl/sevseg_mux_if.sv | 23 ++
 rtl/sevseg_mux.sv | 112 +++++++++++
 tb/tb_sevseg_mux.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sevseg_mux_if.sv
// rtl/sevseg_mux_if.sv - Display-data load port and multiplexed LED drive signals for sevseg_mux
interface sevseg_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_mask;
  logic                  load;
  logic [6:0]            ca;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  modport master (
    output value, dp_in, blank_mask, load,
    input  ca, dp, an, frame_tick
  );

  modport slave (
    input  value, dp_in, blank_mask, load,
    output ca, dp, an, frame_tick
  );
endinterface

// File: rtl/sevseg_mux.sv
// rtl/sevseg_mux.sv - Time-multiplexed hex seven-segment driver with frame-synchronous double buffering
// Loaded data waits in a shadow copy and only becomes visible at a frame boundary, so a frame never tears.
module sevseg_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit LZB_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  sevseg_mux_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] sh_value, act_value;
  logic [N_DIGITS-1:0]   sh_dp, act_dp;
  logic [N_DIGITS-1:0]   sh_blank, act_blank;
  logic                  pending;
  logic                  frame_tick_q;
  logic [6:0]            ca_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   an_q;

  logic                  tc;
  logic                  frame_end;
  logic [3:0]            nib;
  logic [4*N_DIGITS-1:0] upper;
  logic                  lzb;
  logic                  blank_now;
  logic [6:0]            seg;

  always_comb begin
    tc        = (presc == PRESC_LAST);
    frame_end = tc && (idx == IDX_LAST);
    nib       = act_value[4*idx +: 4];
    // Current digit plus every more-significant one, for leading-zero detection.
    upper     = act_value >> (4 * idx);
    lzb       = LZB_EN && (idx != '0) && (upper == '0);
    blank_now = act_blank[idx] | lzb;
    case (nib)
      4'h0:    seg = 7'h01;
      4'h1:    seg = 7'h4F;
      4'h2:    seg = 7'h12;
      4'h3:    seg = 7'h06;
      4'h4:    seg = 7'h4C;
      4'h5:    seg = 7'h24;
      4'h6:    seg = 7'h20;
      4'h7:    seg = 7'h0F;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h04;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h60;
      4'hC:    seg = 7'h31;
      4'hD:    seg = 7'h42;
      4'hE:    seg = 7'h30;
      default: seg = 7'h38;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      act_value    <= '0;
      act_dp       <= '0;
      act_blank    <= '0;
      pending      <= 1'b0;
      frame_tick_q <= 1'b0;
      ca_q         <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      presc <= tc ? '0 : presc + PW'(1);
      if (tc) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end

      if (bus.load) begin
        sh_value <= bus.value;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_mask;
      end

      // A load landing on the boundary edge bypasses the shadow so it shows this frame.
      if (frame_end && (pending || bus.load)) begin
        act_value <= bus.load ? bus.value      : sh_value;
        act_dp    <= bus.load ? bus.dp_in      : sh_dp;
        act_blank <= bus.load ? bus.blank_mask : sh_blank;
        pending   <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      frame_tick_q <= frame_end;
      an_q         <= ~(N_DIGITS'(1) << idx);
      ca_q         <= blank_now ? 7'h7F : seg;
      dp_q         <= blank_now | ~act_dp[idx];
    end
  end

  assign bus.ca         = ca_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sevseg_mux.sv
// tb/tb_sevseg_mux.sv - Self-checking bench for sevseg_mux (N=4, DIV=4, with and without blanking)
module tb_sevseg_mux;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sevseg_mux_if #(.N_DIGITS(N)) bus0 ();
  sevseg_mux_if #(.N_DIGITS(N)) bus1 ();

  assign bus1.value      = bus0.value;
  assign bus1.dp_in      = bus0.dp_in;
  assign bus1.blank_mask = bus0.blank_mask;
  assign bus1.load       = bus0.load;

  sevseg_mux #(.N_DIGITS(N), .REFRESH_DIV(DIV), .LZB_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  sevseg_mux #(.N_DIGITS(N), .REFRESH_DIV(DIV), .LZB_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a cycle counter since reset plus shadow/active copies.
  int          t;
  logic [15:0] m_sh_v, m_act_v;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  bit          m_pend;
  logic [6:0]  seg_tab [16];

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic [3:0]      blank;
    logic [3:0][6:0] ca_lzb;
    logic [3:0][6:0] ca_raw;
    logic [3:0]      dp_exp;
  } vec_t;
  vec_t vec [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] render(int idx, logic [15:0] v, logic [3:0] dpv,
                                         logic [3:0] bl, bit lzb);
    logic [3:0] an_e;
    logic [3:0] nib;
    logic [6:0] ca_e;
    logic       dp_e;
    bit         blank;
    an_e      = 4'hF;
    an_e[idx] = 1'b0;
    nib       = v[4*idx +: 4];
    blank     = bl[idx];
    if (lzb && idx > 0 && (v >> (4 * idx)) == 16'h0) blank = 1'b1;
    ca_e = blank ? 7'h7F : seg_tab[nib];
    dp_e = blank ? 1'b1 : ~dpv[idx];
    return {an_e, ca_e, dp_e};
  endfunction

  task automatic tick();
    logic [11:0] e0, e1;
    logic        fe;
    int          idx;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      t = 0;
      m_sh_v = '0; m_sh_dp = '0; m_sh_bl = '0;
      m_act_v = '0; m_act_dp = '0; m_act_bl = '0;
      m_pend = 1'b0;
      e0 = {4'hF, 7'h7F, 1'b1};
      e1 = e0;
      fe = 1'b0;
    end else begin
      idx = (t / DIV) % N;
      e0  = render(idx, m_act_v, m_act_dp, m_act_bl, 1'b1);
      e1  = render(idx, m_act_v, m_act_dp, m_act_bl, 1'b0);
      fe  = (t % DIV == DIV - 1) && (idx == N - 1);
      if (bus0.load) begin
        m_sh_v = bus0.value; m_sh_dp = bus0.dp_in; m_sh_bl = bus0.blank_mask;
        m_pend = 1'b1;
      end
      if (fe && m_pend) begin
        m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
        m_pend = 1'b0;
      end
      t++;
    end
    chk("lzb an", bus0.an, e0[11:8]);
    chk("lzb ca", bus0.ca, e0[7:1]);
    chk("lzb dp", bus0.dp, e0[0]);
    chk("lzb frame_tick", bus0.frame_tick, fe);
    chk("raw an", bus1.an, e1[11:8]);
    chk("raw ca", bus1.ca, e1[7:1]);
    chk("raw dp", bus1.dp, e1[0]);
    chk("raw frame_tick", bus1.frame_tick, fe);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus0.value = v; bus0.dp_in = d; bus0.blank_mask = b; bus0.load = 1'b1;
    tick();
    bus0.load = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int k = 0; k < 3 * FRAME && !seen; k++) begin
      tick();
      seen = bus0.frame_tick;
    end
    chk("wait_frame seen", seen, 1);
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < FRAME && (t % FRAME) != ph; k++) tick();
    chk("wait_phase reached", t % FRAME, ph);
  endtask

  initial begin
    logic [3:0] an_exp;
    int         d, cnt;
    seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    vec[0] = '{16'h12AF, 4'b0000, 4'b0000, {7'h4F, 7'h12, 7'h08, 7'h38},
               {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1111};
    vec[1] = '{16'h0005, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h24},
               {7'h01, 7'h01, 7'h01, 7'h24}, 4'b1111};
    vec[2] = '{16'h8888, 4'b0100, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h7F},
               {7'h00, 7'h00, 7'h00, 7'h7F}, 4'b1011};
    vec[3] = '{16'h0000, 4'b1111, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h01},
               {7'h01, 7'h01, 7'h01, 7'h01}, 4'b1110};
    vec[4] = '{16'h0F00, 4'b0000, 4'b0000, {7'h7F, 7'h38, 7'h01, 7'h01},
               {7'h01, 7'h38, 7'h01, 7'h01}, 4'b1111};

    // Reset with a load asserted: the load must be ignored.
    rst_n = 1'b0;
    bus0.value = 16'hFFFF; bus0.dp_in = 4'hF; bus0.blank_mask = 4'h0; bus0.load = 1'b1;
    tick();
    tick();
    bus0.load = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 5; v++) begin
      do_load(vec[v].value, vec[v].dp_in, vec[v].blank);
      wait_frame();
      for (int k = 0; k < FRAME; k++) begin
        tick();
        d      = k / DIV;
        an_exp = 4'hF;
        an_exp[d] = 1'b0;
        chk("vec an", bus0.an, an_exp);
        chk("vec ca lzb", bus0.ca, vec[v].ca_lzb[d]);
        chk("vec ca raw", bus1.ca, vec[v].ca_raw[d]);
        chk("vec dp", bus0.dp, vec[v].dp_exp[d]);
      end
    end

    // Load mid-frame stays hidden until the wrap; frame_tick once per frame.
    wait_phase(5);
    do_load(16'h4321, 4'h0, 4'h0);
    cnt = 0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      tick();
      cnt += int'(bus0.frame_tick);
    end
    chk("frame_tick count", cnt, 4);

    // Two loads in one frame: only the second is ever shown.
    wait_frame();
    do_load(16'h1111, 4'h0, 4'h0);
    tick();
    do_load(16'h2222, 4'h0, 4'h0);
    wait_frame();
    for (int k = 0; k < FRAME; k++) begin
      tick();
      chk("last load wins", bus0.ca, 7'h12);
    end

    // Load exactly on the boundary edge is shown in the very next frame.
    wait_phase(FRAME - 1);
    do_load(16'h3333, 4'h0, 4'h0);
    chk("coincident frame_tick", bus0.frame_tick, 1);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      chk("coincident shown", bus0.ca, 7'h06);
    end

    // One-cycle reset mid-frame discards a pending load.
    wait_phase(5);
    do_load(16'h7777, 4'h0, 4'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset an", bus0.an, 4'hF);
    chk("reset ca", bus0.ca, 7'h7F);
    chk("reset dp", bus0.dp, 1);
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      chk("pending discarded", bus0.ca == 7'h0F, 0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst_n           = ($urandom_range(0, 149) != 0);
      bus0.load       = ($urandom_range(0, 5) == 0);
      bus0.value      = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      bus0.dp_in      = 4'($urandom);
      bus0.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
